// File: rtl/vgachargen_pkg.sv
// Shared definitions for the text-mode display CPU-side access path:
// region bases, memory depths, FSM state codes, region enum and the
// APB address decoder.
package vgachargen_pkg;

  localparam int unsigned APB_AW  = 14;
  localparam int unsigned APB_DW  = 32;
  localparam int unsigned APB_SW  = 4;
  localparam int unsigned GLYPH_W = 128;

  localparam logic [APB_AW-1:0] CH_MAP_BASE  = 14'h0000;
  localparam logic [APB_AW-1:0] COL_MAP_BASE = 14'h1000;
  localparam logic [APB_AW-1:0] CH_T_RW_BASE = 14'h2000;

  localparam int unsigned MAP_DEPTH   = 2400;
  localparam int unsigned GLYPH_DEPTH = 128;

  // FSM state encoding
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_BYTE     = 3'd1;
  localparam logic [2:0] ST_GLYPH_RD = 3'd2;
  localparam logic [2:0] ST_GLYPH_WR = 3'd3;
  localparam logic [2:0] ST_DONE     = 3'd4;

  typedef enum logic [1:0] {
    REG_CH    = 2'd0,
    REG_COL   = 2'd1,
    REG_GLYPH = 2'd2,
    REG_ERR   = 2'd3
  } region_e;

  // Classify a byte address; word holes past the populated depth are errors.
  function automatic region_e decode_addr(input logic [APB_AW-1:0] paddr,
                                          input int unsigned map_depth,
                                          input int unsigned glyph_depth);
    region_e r;
    r = REG_ERR;
    if ((paddr[13:12] == CH_MAP_BASE[13:12]) &&
        (32'({paddr[11:2], 2'b00}) < map_depth)) begin
      r = REG_CH;
    end else if ((paddr[13:12] == COL_MAP_BASE[13:12]) &&
                 (32'({paddr[11:2], 2'b00}) < map_depth)) begin
      r = REG_COL;
    end else if ((paddr[13:11] == CH_T_RW_BASE[13:11]) &&
                 (32'(paddr[10:4]) < glyph_depth)) begin
      r = REG_GLYPH;
    end
    return r;
  endfunction

endpackage

// File: rtl/vgachargen_apb_writer_if.sv
// APB slave bus bundle for the display-memory writer.
// master: drives psel/penable/pwrite/paddr/pwdata/pstrb, receives response.
// slave : receives request, drives prdata/pready/pslverr.
interface vgachargen_apb_writer_if;
  import vgachargen_pkg::*;

  logic              psel_i;
  logic              penable_i;
  logic              pwrite_i;
  logic [APB_AW-1:0] paddr_i;
  logic [APB_DW-1:0] pwdata_i;
  logic [APB_SW-1:0] pstrb_i;
  logic [APB_DW-1:0] prdata_o;
  logic              pready_o;
  logic              pslverr_o;

  modport master (
    output psel_i, penable_i, pwrite_i, paddr_i, pwdata_i, pstrb_i,
    input  prdata_o, pready_o, pslverr_o
  );

  modport slave (
    input  psel_i, penable_i, pwrite_i, paddr_i, pwdata_i, pstrb_i,
    output prdata_o, pready_o, pslverr_o
  );
endinterface

// File: rtl/vgachargen_apb_writer.sv
// APB slave giving the CPU access to the character map, color map and
// writable glyph table A ports. Map words are split into four byte
// accesses; glyph words are read-modify-written into 128-bit lines.
// Ports:
//   clk_i, arst_i        : clock, asynchronous active-high reset
//   apb                  : APB slave bundle (request in, response out)
//   ch_map_*             : character map A port (addr/wen/wdata out, rdata in)
//   col_map_*            : color map A port, byte = {fg, bg}
//   ch_t_rw_*            : glyph table A port, 128-bit lines
module vgachargen_apb_writer
  import vgachargen_pkg::*;
#(
  parameter int unsigned MAP_DEPTH   = vgachargen_pkg::MAP_DEPTH,
  parameter int unsigned GLYPH_DEPTH = vgachargen_pkg::GLYPH_DEPTH,
  parameter int unsigned MAP_AW      = $clog2(MAP_DEPTH),
  parameter int unsigned GLYPH_AW    = $clog2(GLYPH_DEPTH)
) (
  input  logic                clk_i,
  input  logic                arst_i,
  vgachargen_apb_writer_if.slave apb,
  output logic [MAP_AW-1:0]   ch_map_addr_o,
  output logic                ch_map_wen_o,
  output logic [7:0]          ch_map_data_o,
  input  logic [7:0]          ch_map_data_i,
  output logic [MAP_AW-1:0]   col_map_addr_o,
  output logic                col_map_wen_o,
  output logic [7:0]          col_map_data_o,
  input  logic [7:0]          col_map_data_i,
  output logic [GLYPH_AW-1:0] ch_t_rw_addr_o,
  output logic                ch_t_rw_wen_o,
  output logic [GLYPH_W-1:0]  ch_t_rw_data_o,
  input  logic [GLYPH_W-1:0]  ch_t_rw_data_i
);

  logic [2:0]        state_q,   state_d;
  logic [2:0]        cnt_q,     cnt_d;
  region_e           region_q,  region_d;
  logic              pwrite_q,  pwrite_d;
  logic [9:0]        word_q,    word_d;
  logic [APB_DW-1:0] wdata_q,   wdata_d;
  logic [APB_SW-1:0] strb_q,    strb_d;
  logic              err_q,     err_d;
  logic [APB_DW-1:0] prdata_q,  prdata_d;
  logic              pready_q,  pready_d;
  logic              pslverr_q, pslverr_d;

  logic [7:0]         map_rdata;
  logic [7:0]         lane_byte;
  logic               lane_wen;
  logic [MAP_AW-1:0]  map_entry;
  logic [31:0]        glyph_word;
  logic [GLYPH_W-1:0] glyph_merged;

  // Byte-offset bits carry no information for word accesses.
  logic unused_paddr_lo;
  assign unused_paddr_lo = ^apb.paddr_i[1:0];

  assign apb.prdata_o  = prdata_q;
  assign apb.pready_o  = pready_q;
  assign apb.pslverr_o = pslverr_q;

  // Datapath helpers: lane select, map entry, glyph word extract and merge.
  always_comb begin
    map_rdata    = (region_q == REG_COL) ? col_map_data_i : ch_map_data_i;
    lane_byte    = '0;
    glyph_word   = '0;
    glyph_merged = ch_t_rw_data_i;
    map_entry    = MAP_AW'({word_q, 2'b00}) + MAP_AW'(cnt_q);
    for (int k = 0; k < 4; k++) begin
      if (cnt_q[1:0] == 2'(k)) lane_byte = wdata_q[8*k +: 8];
    end
    lane_wen = pwrite_q & strb_q[cnt_q[1:0]] & ~cnt_q[2];
    for (int w = 0; w < 4; w++) begin
      if (word_q[1:0] == 2'(w)) begin
        glyph_word = ch_t_rw_data_i[32*w +: 32];
        for (int b = 0; b < 4; b++) begin
          if (strb_q[b]) glyph_merged[32*w + 8*b +: 8] = wdata_q[8*b +: 8];
        end
      end
    end
  end

  // Next-state and response logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    region_d  = region_q;
    pwrite_d  = pwrite_q;
    word_d    = word_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    err_d     = err_q;
    prdata_d  = prdata_q;
    case (state_q)
      ST_IDLE: begin
        if (apb.psel_i && !apb.penable_i) begin
          pwrite_d = apb.pwrite_i;
          word_d   = apb.paddr_i[11:2];
          wdata_d  = apb.pwdata_i;
          strb_d   = apb.pstrb_i;
          region_d = decode_addr(apb.paddr_i, MAP_DEPTH, GLYPH_DEPTH);
          err_d    = (region_d == REG_ERR);
          cnt_d    = 3'd0;
          case (region_d)
            REG_CH, REG_COL: state_d = ST_BYTE;
            REG_GLYPH:       state_d = ST_GLYPH_RD;
            default:         state_d = ST_DONE;
          endcase
        end
      end
      ST_BYTE: begin
        // Read data lags the address by one cycle, so cnt=k returns lane k-1.
        if (!pwrite_q) begin
          for (int k = 0; k < 4; k++) begin
            if (cnt_q == 3'(k + 1)) prdata_d[8*k +: 8] = map_rdata;
          end
        end
        if (cnt_q == 3'd4) state_d = ST_DONE;
        else               cnt_d   = cnt_q + 3'd1;
      end
      ST_GLYPH_RD: state_d = ST_GLYPH_WR;
      ST_GLYPH_WR: begin
        if (!pwrite_q) prdata_d = glyph_word;
        state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    pready_d  = (state_d == ST_DONE);
    pslverr_d = (state_d == ST_DONE) & err_d;
  end

  // Memory A-port drive, decoded from the current state.
  always_comb begin
    ch_map_addr_o  = '0;
    ch_map_wen_o   = 1'b0;
    ch_map_data_o  = '0;
    col_map_addr_o = '0;
    col_map_wen_o  = 1'b0;
    col_map_data_o = '0;
    ch_t_rw_addr_o = '0;
    ch_t_rw_wen_o  = 1'b0;
    ch_t_rw_data_o = '0;
    case (state_q)
      ST_BYTE: begin
        if (!cnt_q[2]) begin
          if (region_q == REG_COL) begin
            col_map_addr_o = map_entry;
            col_map_wen_o  = lane_wen;
            col_map_data_o = lane_wen ? lane_byte : 8'h00;
          end else begin
            ch_map_addr_o = map_entry;
            ch_map_wen_o  = lane_wen;
            ch_map_data_o = lane_wen ? lane_byte : 8'h00;
          end
        end
      end
      ST_GLYPH_RD: ch_t_rw_addr_o = GLYPH_AW'(word_q[8:2]);
      ST_GLYPH_WR: begin
        ch_t_rw_addr_o = GLYPH_AW'(word_q[8:2]);
        if (pwrite_q) begin
          ch_t_rw_wen_o  = 1'b1;
          ch_t_rw_data_o = glyph_merged;
        end
      end
      default: ;
    endcase
  end

  // State and response registers.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      region_q  <= REG_CH;
      pwrite_q  <= 1'b0;
      word_q    <= '0;
      wdata_q   <= '0;
      strb_q    <= '0;
      err_q     <= 1'b0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      region_q  <= region_d;
      pwrite_q  <= pwrite_d;
      word_q    <= word_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      err_q     <= err_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
    end
  end

endmodule

// File: tb/tb_vgachargen_apb_writer.sv
module tb_vgachargen_apb_writer;
  localparam int unsigned MAW = 12;
  localparam int unsigned GAW = 7;
  localparam logic [127:0] GL3 = 128'h0123456789ABCDEF0123456789ABCDEF;

  logic clk = 1'b0;
  logic arst;
  logic init;
  always #5 clk = ~clk;

  vgachargen_apb_writer_if apb_if();

  logic [MAW-1:0] ch_addr, col_addr;
  logic           ch_wen, col_wen, gl_wen;
  logic [7:0]     ch_wdata, col_wdata, ch_rdata, col_rdata;
  logic [GAW-1:0] gl_addr;
  logic [127:0]   gl_wdata, gl_rdata;

  vgachargen_apb_writer dut (
    .clk_i(clk), .arst_i(arst), .apb(apb_if),
    .ch_map_addr_o(ch_addr), .ch_map_wen_o(ch_wen),
    .ch_map_data_o(ch_wdata), .ch_map_data_i(ch_rdata),
    .col_map_addr_o(col_addr), .col_map_wen_o(col_wen),
    .col_map_data_o(col_wdata), .col_map_data_i(col_rdata),
    .ch_t_rw_addr_o(gl_addr), .ch_t_rw_wen_o(gl_wen),
    .ch_t_rw_data_o(gl_wdata), .ch_t_rw_data_i(gl_rdata)
  );

  // Registered-read memory models, one-cycle latency.
  logic [7:0]   ch_mem  [0:4095];
  logic [7:0]   col_mem [0:4095];
  logic [127:0] gl_mem  [0:127];
  always @(posedge clk) begin
    if (init) begin
      for (int i = 0; i < 4096; i++) begin
        ch_mem[i]  <= 8'(i);
        col_mem[i] <= ~8'(i);
      end
      for (int i = 0; i < 128; i++) gl_mem[i] <= (i == 3) ? GL3 : '0;
    end else begin
      if (ch_wen)  ch_mem[ch_addr]   <= ch_wdata;
      if (col_wen) col_mem[col_addr] <= col_wdata;
      if (gl_wen)  gl_mem[gl_addr]   <= gl_wdata;
    end
    ch_rdata  <= ch_mem[ch_addr];
    col_rdata <= col_mem[col_addr];
    gl_rdata  <= gl_mem[gl_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Write-enable monitor: counts, first/last pulse cycle, overlap.
  int ch_cnt = 0, col_cnt = 0, gl_cnt = 0, multi = 0;
  int ch_first = 0, ch_last = 0, col_first = 0, col_last = 0, gl_first = 0;
  int ch_mark = 0, col_mark = 0;
  always @(negedge clk) begin
    if (!arst) begin
      if (32'(ch_wen) + 32'(col_wen) + 32'(gl_wen) > 1) multi++;
      if (ch_wen) begin
        if (ch_cnt == ch_mark) ch_first = cyc;
        ch_cnt++;
        ch_last = cyc;
      end
      if (col_wen) begin
        if (col_cnt == col_mark) col_first = cyc;
        col_cnt++;
        col_last = cyc;
      end
      if (gl_wen) begin
        gl_cnt++;
        gl_first = cyc;
      end
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int t0;

  task automatic apb(input logic w, input logic [13:0] a, input logic [31:0] d,
                     input logic [3:0] s, output int lat, output logic [31:0] rd,
                     output logic err);
    logic got;
    t0 = cyc;
    apb_if.psel_i    = 1'b1;
    apb_if.penable_i = 1'b0;
    apb_if.pwrite_i  = w;
    apb_if.paddr_i   = a;
    apb_if.pwdata_i  = d;
    apb_if.pstrb_i   = s;
    @(posedge clk); #1;
    apb_if.penable_i = 1'b1;
    lat = 1;
    got = 1'b0;
    rd  = 'x;
    err = 1'bx;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (apb_if.pready_o) begin
        got = 1'b1;
        rd  = apb_if.prdata_o;
        err = apb_if.pslverr_o;
      end else begin
        @(posedge clk); #1;
        lat++;
      end
    end
    if (!got) lat = -1;
    @(posedge clk); #1;
    apb_if.psel_i    = 1'b0;
    apb_if.penable_i = 1'b0;
    apb_if.pwrite_i  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  int          lat;
  logic [31:0] rd;
  logic        err;
  int          wen_before;

  initial begin
    arst = 1'b1;
    init = 1'b1;
    apb_if.psel_i = 1'b0; apb_if.penable_i = 1'b0; apb_if.pwrite_i = 1'b0;
    apb_if.paddr_i = '0;  apb_if.pwdata_i = '0;   apb_if.pstrb_i = '0;
    repeat (2) @(posedge clk);
    #1 init = 1'b0;
    @(negedge clk);
    chk("rst_pready",  apb_if.pready_o,  0);
    chk("rst_pslverr", apb_if.pslverr_o, 0);
    chk("rst_prdata",  apb_if.prdata_o,  0);
    chk("rst_mem_out", {ch_wen, col_wen, gl_wen, ch_addr, col_addr, gl_addr, ch_wdata, col_wdata}, 0);
    chk("rst_gl_data", gl_wdata, 0);
    @(posedge clk); #1 arst = 1'b0;
    @(posedge clk); #1;

    // Full-strobe character map write
    ch_mark = ch_cnt;
    apb(1'b1, 14'h0000, 32'h44434241, 4'hF, lat, rd, err);
    chk("wr_ch_lat", 32'(lat), 6);
    chk("wr_ch_err", err, 0);
    chk("wr_ch_prdata_hold", rd, 0);
    chk("wr_ch_mem", {ch_mem[3], ch_mem[2], ch_mem[1], ch_mem[0]}, 32'h44434241);
    chk("wr_ch_wen_cnt", 32'(ch_cnt - ch_mark), 4);
    chk("wr_ch_first_T", 32'(ch_first - t0), 1);
    chk("wr_ch_last_T",  32'(ch_last - t0), 4);

    // Sparse-strobe color map write
    col_mark = col_cnt;
    apb(1'b1, 14'h1004, 32'hA5A5F00F, 4'b0101, lat, rd, err);
    chk("wr_col_lat", 32'(lat), 6);
    chk("wr_col_mem", {col_mem[7], col_mem[6], col_mem[5], col_mem[4]}, 32'hF8A5FA0F);
    chk("wr_col_wen_cnt", 32'(col_cnt - col_mark), 2);
    chk("wr_col_first_T", 32'(col_first - t0), 1);
    chk("wr_col_last_T",  32'(col_last - t0), 3);

    // Glyph read-modify-write and readback
    apb(1'b1, 14'h2038, 32'hDEADBEEF, 4'hF, lat, rd, err);
    chk("wr_gl_lat", 32'(lat), 3);
    chk("wr_gl_wen_T", 32'(gl_first - t0), 2);
    chk("wr_gl_line", gl_mem[3], 128'h01234567DEADBEEF0123456789ABCDEF);
    apb(1'b0, 14'h2038, 32'h0, 4'hF, lat, rd, err);
    chk("rd_gl_lat", 32'(lat), 3);
    chk("rd_gl_data", rd, 32'hDEADBEEF);
    chk("rd_gl_err", err, 0);
    apb(1'b1, 14'h2034, 32'h11223344, 4'b1001, lat, rd, err);
    chk("wr_gl_part_line", gl_mem[3], 128'h01234567DEADBEEF1123454489ABCDEF);
    chk("wr_gl_prdata_hold", rd, 32'hDEADBEEF);

    // Out-of-range accesses
    wen_before = ch_cnt + col_cnt + gl_cnt;
    apb(1'b0, 14'h0960, 32'h0, 4'hF, lat, rd, err);
    chk("err_hole_lat", 32'(lat), 1);
    chk("err_hole_slverr", err, 1);
    chk("err_hole_prdata", rd, 32'hDEADBEEF);
    apb(1'b1, 14'h3000, 32'hFFFFFFFF, 4'hF, lat, rd, err);
    chk("err_3000_lat", 32'(lat), 1);
    chk("err_3000_slverr", err, 1);
    chk("err_3000_prdata", rd, 32'hDEADBEEF);
    chk("err_no_wen", 32'(ch_cnt + col_cnt + gl_cnt - wen_before), 0);

    // Last valid map word
    apb(1'b0, 14'h095C, 32'h0, 4'hF, lat, rd, err);
    chk("rd_last_lat", 32'(lat), 6);
    chk("rd_last_data", rd, 32'h5F5E5D5C);
    chk("rd_last_err", err, 0);

    // Reset mid map write while lane 2 is on the bus
    t0 = cyc;
    apb_if.psel_i = 1'b1; apb_if.penable_i = 1'b0; apb_if.pwrite_i = 1'b1;
    apb_if.paddr_i = 14'h0010; apb_if.pwdata_i = 32'h11223344; apb_if.pstrb_i = 4'hF;
    @(posedge clk); #1 apb_if.penable_i = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_lane2_addr", {ch_wen, ch_addr}, {1'b1, 12'd18});
    arst = 1'b1;
    #1;
    chk("mid_rst_outs", {ch_wen, col_wen, gl_wen, ch_addr, ch_wdata, apb_if.pready_o, apb_if.pslverr_o}, 0);
    chk("mid_rst_prdata", apb_if.prdata_o, 0);
    apb_if.psel_i = 1'b0; apb_if.penable_i = 1'b0; apb_if.pwrite_i = 1'b0;
    @(posedge clk); #1 arst = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_mem", {ch_mem[19], ch_mem[18], ch_mem[17], ch_mem[16]}, 32'h13123344);
    apb(1'b0, 14'h0010, 32'h0, 4'hF, lat, rd, err);
    chk("post_rst_lat", 32'(lat), 6);
    chk("post_rst_data", rd, 32'h13123344);

    // Back-to-back reads, second setup in the cycle after DONE
    apb(1'b0, 14'h0000, 32'h0, 4'hF, lat, rd, err);
    chk("b2b_ch_lat", 32'(lat), 6);
    chk("b2b_ch_data", rd, 32'h44434241);
    apb(1'b0, 14'h1000, 32'h0, 4'hF, lat, rd, err);
    chk("b2b_col_lat", 32'(lat), 6);
    chk("b2b_col_data", rd, 32'hFCFDFEFF);
    chk("b2b_col_err", err, 0);

    chk("wen_overlap", 32'(multi), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vgachargen_apb_writer.md
# vgachargen_apb_writer

APB3/APB4 slave that gives the CPU access to the text-mode display memories. It writes and reads back the character map, the color map and the writable glyph table through their A ports, while the pixel pipeline uses the B ports. It sits between the system APB interconnect and the display core. It converts 32-bit APB words into byte-wide map accesses and into read-modify-write cycles on 128-bit glyph lines.

## Interface
Parameters:
- `MAP_DEPTH`, default 2400: character and color map entries (80x30).
- `GLYPH_DEPTH`, default 128: writable glyph lines.
- `MAP_AW`, default `$clog2(MAP_DEPTH)`: map address width.
- `GLYPH_AW`, default `$clog2(GLYPH_DEPTH)`: glyph address width.

Ports:
- `clk_i` in 1: single clock for the whole block.
- `arst_i` in 1: reset, asynchronous, active-high.
- `psel_i`, `penable_i`, `pwrite_i` in 1 each: APB control.
- `paddr_i` in 14: byte address. Bits [1:0] are ignored.
- `pwdata_i` in 32: write data.
- `pstrb_i` in 4: byte strobes. Tie to 4'hF for APB3.
- `prdata_o` out 32, `pready_o` out 1, `pslverr_o` out 1: APB response.
- `ch_map_addr_o` out MAP_AW, `ch_map_wen_o` out 1, `ch_map_data_o` out 8, `ch_map_data_i` in 8: character map A port.
- `col_map_addr_o` out MAP_AW, `col_map_wen_o` out 1, `col_map_data_o` out 8, `col_map_data_i` in 8: color map A port. Color byte layout is {fg[3:0], bg[3:0]}.
- `ch_t_rw_addr_o` out GLYPH_AW, `ch_t_rw_wen_o` out 1, `ch_t_rw_data_o` out 128, `ch_t_rw_data_i` in 128: glyph table A port.

## Operation
Address map (byte addresses). Word-sized holes inside a region are out of range.
- 0x0000–0x095F: character map. 4 characters per word, lane k maps to entry (paddr>>2)*4+k.
- 0x1000–0x195F: color map, same packing as the character map.
- 0x2000–0x27FF: glyph table. Glyph g = paddr[10:4], word w = paddr[3:2], which maps to line bits [32w+31:32w].
- Any other address: PSLVERR. No memory enable is asserted.

FSM states are IDLE, BYTE, GLYPH_RD, GLYPH_WR and DONE.
- IDLE, on `psel_i & !penable_i` (setup phase):
  - latch addr, pwrite, pwdata, pstrb;
  - decode the address;
  - map region → BYTE with cnt=0; glyph region → GLYPH_RD; error → DONE with err=1.
- BYTE, cnt 0..4:
  - cnt<4 drives map addr = base+cnt;
  - on a write, wen=1 and data=lane cnt if pstrb[cnt]. Lanes with a clear strobe take the cycle with wen=0;
  - on a read, cnt>0 captures data_i into prdata lane cnt-1;
  - cnt==4 → DONE.
- GLYPH_RD: drives `ch_t_rw_addr_o` → GLYPH_WR.
- GLYPH_WR:
  - on a read, captures word w of data_i into prdata;
  - on a write, merges the strobed bytes of pwdata into word w of data_i, drives the merged line with wen=1 for one cycle. Other words and bytes are preserved;
  - → DONE.
- DONE: `pready_o`=1 and `pslverr_o`=err for exactly one cycle → IDLE.

General rules:
- Every wen is a single-cycle pulse. At most one memory is enabled per cycle.
- `prdata_o` changes only on read captures. It holds its value through writes and errors.
- A transfer, once latched, always runs to completion, even if `psel_i` drops (protocol violation). The DONE pulse is then ignored.
- `pwrite_i=0` never asserts any wen.

Reset (`arst_i`=1, asynchronous): state=IDLE. All outputs are 0: `pready_o`, `pslverr_o`, `prdata_o`, all addresses, data and wens.

## Timing
- Memory A ports have 1-cycle registered read latency: data_i is valid the cycle after the address.
- Setup cycle is T0. `pready_o`=1 at:
  - T6 for map access (5 wait states);
  - T3 for glyph access (2 wait states);
  - T1 for an error (0 wait states).
- Byte write lane k: wen in T(k+1). Glyph write: wen in T2.
- Back-to-back: the next setup phase may come in the cycle after DONE and is accepted.
- There is no collision logic against the B ports; the dual-port memories handle it.

## Structure
- Shared package `vgachargen_pkg` holds:
  - region bases (CH_MAP_BASE=14'h0000, COL_MAP_BASE=14'h1000, CH_T_RW_BASE=14'h2000);
  - MAP_DEPTH and GLYPH_DEPTH;
  - the state enum;
  - a region enum {REG_CH, REG_COL, REG_GLYPH, REG_ERR};
  - the `decode_addr` function.
- The block is a single module with no sub-modules.

## Test plan
- Write 0x0000 data 0x44434241 strb 4'hF → `ch_map` wen at entries 0..3 with bytes 41,42,43,44. pready at T6, pslverr=0.
- Write 0x1004 data 0xA5A5_F00F strb 4'b0101 → `col_map` wen only at entry 4 (0x0F) and entry 6 (0xA5). Entries 5 and 7 untouched.
- Preload glyph 3 = 128'h0123…EF. Write 0x2038 data 0xDEADBEEF strb 4'hF → line 3 bits [95:64]=DEADBEEF, other bits unchanged. Read back 0x2038 → prdata 0xDEADBEEF at T3.
- Read 0x0960 and 0x3000 → pslverr=1 and pready at T1. No wen, prdata unchanged.
- Assert `arst_i` in the middle of a map write (cnt=2) → outputs 0 immediately, lanes 2 and 3 not written. The next transfer completes normally.
- Two back-to-back reads (0x0000 then 0x1000) → both return the correct packed bytes with no dropped setup phase.
